fib_instr_seq: RTL



---
 rtl/fib_isa_pkg.sv | 54 +++++
 rtl/fib_instr_seq_if.sv | 26 ++
 rtl/fib_prog_rom.sv | 42 ++++
 rtl/fib_instr_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fib_isa_pkg.sv
// rtl/fib_isa_pkg.sv - shared ISA constants, instruction word and sequencer state
// FIB_STORE_EN selects the 5-word loop body (STORE R1 inside the loop).
package fib_isa_pkg;

  localparam int OP_W  = 3;
  localparam int REG_W = 2;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [REG_W-1:0] reg_t;

  localparam op_t OP_NOOP  = 3'b000;
  localparam op_t OP_SET   = 3'b001;
  localparam op_t OP_INC   = 3'b010;
  localparam op_t OP_DEC   = 3'b011;
  localparam op_t OP_LOAD  = 3'b100;
  localparam op_t OP_STORE = 3'b101;
  localparam op_t OP_ADD   = 3'b110;
  localparam op_t OP_COPY  = 3'b111;

  localparam reg_t R0 = 2'd0;
  localparam reg_t R1 = 2'd1;
  localparam reg_t R2 = 2'd2;
  localparam reg_t R3 = 2'd3;

  typedef struct packed {
    op_t  op;
    reg_t opr1;
    reg_t opr2;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_BODY,
    ST_TAIL,
    ST_FIN
  } seq_state_t;

  localparam int PRE_LEN = 4;
`ifdef FIB_STORE_EN
  localparam int BODY_LEN = 5;
`else
  localparam int BODY_LEN = 4;
`endif

  function automatic instr_t mk_instr(op_t op, reg_t opr1, reg_t opr2);
    instr_t w;
    w.op   = op;
    w.opr1 = opr1;
    w.opr2 = opr2;
    return w;
  endfunction

endpackage

// File: rtl/fib_instr_seq_if.sv
// rtl/fib_instr_seq_if.sv - valid/ready instruction word channel toward decode
interface fib_instr_seq_if #(
  parameter int SIZE = 4
);
  logic            instr_valid;
  logic            instr_ready;
  logic [SIZE-2:0] op_code;
  logic [SIZE-3:0] Opr1;
  logic [SIZE-3:0] Opr2;

  modport master (
    output instr_valid,
    output op_code,
    output Opr1,
    output Opr2,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  op_code,
    input  Opr1,
    input  Opr2,
    output instr_ready
  );
endinterface

// File: rtl/fib_prog_rom.sv
// rtl/fib_prog_rom.sv - combinational (state, slot) to instruction word lookup
// FIB_STORE_EN adds STORE R1 as body slot 4 and removes the tail store.
module fib_prog_rom
  import fib_isa_pkg::*;
(
  input  seq_state_t  i_state,
  input  logic [2:0]  i_slot,
  output instr_t      o_instr
);

  always_comb begin
    o_instr = mk_instr(OP_NOOP, R0, R0);
    case (i_state)
      ST_PRE: begin
        case (i_slot)
          3'd0:    o_instr = mk_instr(OP_LOAD, R3, R0);
          3'd1:    o_instr = mk_instr(OP_SET,  R1, R0);
          3'd2:    o_instr = mk_instr(OP_SET,  R0, R0);
          3'd3:    o_instr = mk_instr(OP_DEC,  R0, R0);
          default: o_instr = mk_instr(OP_NOOP, R0, R0);
        endcase
      end
      ST_BODY: begin
        case (i_slot)
          3'd0:    o_instr = mk_instr(OP_COPY,  R2, R1);
          3'd1:    o_instr = mk_instr(OP_ADD,   R1, R0);
          3'd2:    o_instr = mk_instr(OP_COPY,  R0, R2);
          3'd3:    o_instr = mk_instr(OP_DEC,   R3, R0);
`ifdef FIB_STORE_EN
          3'd4:    o_instr = mk_instr(OP_STORE, R1, R0);
`endif
          default: o_instr = mk_instr(OP_NOOP,  R0, R0);
        endcase
      end
`ifndef FIB_STORE_EN
      ST_TAIL: o_instr = mk_instr(OP_STORE, R1, R0);
`endif
      default: o_instr = mk_instr(OP_NOOP, R0, R0);
    endcase
  end

endmodule

// File: rtl/fib_instr_seq.sv
// rtl/fib_instr_seq.sv - Fibonacci program sequencer: preamble, N loop bodies, tail
// FIB_STORE_EN: store every term inside the loop instead of once in the tail.
module fib_instr_seq
  import fib_isa_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  iter_cnt,
  fib_instr_seq_if.master   bus,
  output logic              busy,
  output logic              done
);

  seq_state_t        r_state;
  logic [2:0]        r_slot;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  instr_t            r_instr;

  seq_state_t        w_nxt_state;
  logic [2:0]        w_nxt_slot;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic              w_nxt_valid;
  logic              w_nxt_busy;
  logic              w_nxt_done;
  logic              w_load;
  logic              w_finish;
  logic              w_xfer;
  instr_t            w_rom_instr;

  assign w_xfer = r_valid && bus.instr_ready;

  // The ROM is addressed by the next position so the word lands in r_instr
  // on the same edge that the position advances.
  fib_prog_rom u_rom (
    .i_state (w_nxt_state),
    .i_slot  (w_nxt_slot),
    .o_instr (w_rom_instr)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_slot  = r_slot;
    w_nxt_cnt   = r_cnt;
    w_nxt_valid = r_valid;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nxt_state = ST_PRE;
          w_nxt_slot  = 3'd0;
          w_nxt_cnt   = iter_cnt;
          w_nxt_valid = 1'b1;
          w_nxt_busy  = 1'b1;
          w_load      = 1'b1;
        end
      end
      ST_PRE: begin
        if (w_xfer) begin
          w_load = 1'b1;
          if (r_slot == 3'(PRE_LEN - 1)) begin
            w_nxt_slot = 3'd0;
            if (r_cnt != '0) w_nxt_state = ST_BODY;
            else             w_finish    = 1'b1;
          end else begin
            w_nxt_slot = r_slot + 3'd1;
          end
        end
      end
      ST_BODY: begin
        if (w_xfer) begin
          w_load = 1'b1;
          if (r_slot == 3'(BODY_LEN - 1)) begin
            w_nxt_slot = 3'd0;
            w_nxt_cnt  = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) w_finish = 1'b1;
          end else begin
            w_nxt_slot = r_slot + 3'd1;
          end
        end
      end
      ST_TAIL: begin
        if (w_xfer) begin
          w_load      = 1'b1;
          w_nxt_state = ST_FIN;
          w_nxt_valid = 1'b0;
          w_nxt_busy  = 1'b0;
          w_nxt_done  = 1'b1;
        end
      end
      ST_FIN: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_valid = 1'b0;
        w_nxt_busy  = 1'b0;
      end
    endcase
    if (w_finish) begin
`ifdef FIB_STORE_EN
      w_nxt_state = ST_FIN;
      w_nxt_valid = 1'b0;
      w_nxt_busy  = 1'b0;
      w_nxt_done  = 1'b1;
`else
      w_nxt_state = ST_TAIL;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_slot  <= 3'd0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_instr <= mk_instr(OP_NOOP, R0, R0);
    end else begin
      r_state <= w_nxt_state;
      r_slot  <= w_nxt_slot;
      r_cnt   <= w_nxt_cnt;
      r_valid <= w_nxt_valid;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
      if (w_load) r_instr <= w_rom_instr;
    end
  end

  assign bus.instr_valid = r_valid;
  assign bus.op_code     = (SIZE-1)'(r_instr.op);
  assign bus.Opr1        = (SIZE-2)'(r_instr.opr1);
  assign bus.Opr2        = (SIZE-2)'(r_instr.opr2);
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
